// File: rtl/izh_pkg.sv
// Shared types and constants for the Izhikevich neuron core and its spike decoder.
package izh_pkg;

    // Membrane voltage sample: bits [17:10] of the 2.16 neuron state, i.e. signed 2.6.
    typedef logic signed [7:0] q2_6_t;

    // Spike detector hysteresis states.
    typedef enum logic {
        ARMED,
        FIRED
    } det_state_t;

    // Default spike threshold (~0.30) and rearm level shared with the neuron core.
    localparam q2_6_t THRESH_DEFAULT = 8'sh13;
    localparam q2_6_t REARM_DEFAULT  = 8'sh00;

endpackage

// File: rtl/izh_sat_counter.sv
// Saturating up-counter with clear and load-1; clear has priority over load, load over increment.
module izh_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         load1,
    input  logic         inc,
    output logic [W-1:0] count
);

    // Count register; holds at all-ones once saturated.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (load1) begin
            count <= W'(1);
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/izh_spike_decoder.sv
// Spike detector with hysteresis, inter-spike-interval event port, burst flag and
// windowed spike-rate count for the Izhikevich neuron voltage stream.
module izh_spike_decoder
    import izh_pkg::*;
#(
    parameter int unsigned ISI_W     = 16,
    parameter q2_6_t       THRESH    = THRESH_DEFAULT,
    parameter q2_6_t       REARM     = REARM_DEFAULT,
    parameter int unsigned BURST_ISI = 8,
    parameter int unsigned WIN_LEN   = 1024,
    parameter int unsigned RATE_W    = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              v_valid,
    input  logic signed [7:0] v_in,
    output logic              spike,
    output logic              isi_valid,
    input  logic              isi_ready,
    output logic [ISI_W-1:0]  isi_data,
    output logic              burst,
    output logic              rate_valid,
    output logic [RATE_W-1:0] rate_count,
    output logic              overflow
);

    localparam int unsigned WIN_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);
    // One extra bit so the comparison never wraps for small ISI_W.
    localparam logic [ISI_W:0] BURST_LIM = (ISI_W + 1)'(BURST_ISI);

    det_state_t        state;
    logic              first_seen;
    logic [WIN_W-1:0]  win_pos;
    logic [ISI_W-1:0]  isi_cnt;
    logic [RATE_W-1:0] rate_cnt;

    logic              fire;
    logic              rearm;
    logic              new_evt;
    logic              accept;
    logic              win_last;
    logic              burst_now;
    logic [RATE_W-1:0] rate_next;

    // Per-sample decode: threshold crossing, rearm, event generation and window end.
    always_comb begin
        fire      = v_valid && (state == ARMED) && (v_in > THRESH);
        rearm     = v_valid && (state == FIRED) && (v_in < REARM);
        new_evt   = fire && first_seen;
        accept    = isi_valid && isi_ready;
        win_last  = (win_pos == WIN_LAST);
        burst_now = ({1'b0, isi_cnt} < BURST_LIM);
        rate_next = (rate_cnt == '1) ? rate_cnt : rate_cnt + RATE_W'(1);
    end

    // Samples since the previous spike; a spike reports the count and restarts it at 1.
    izh_sat_counter #(
        .W (ISI_W)
    ) u_isi_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (1'b0),
        .load1 (fire),
        .inc   (v_valid && !fire),
        .count (isi_cnt)
    );

    // Spikes in the current window; cleared on the window's last sample.
    izh_sat_counter #(
        .W (RATE_W)
    ) u_rate_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (v_valid && win_last),
        .load1 (1'b0),
        .inc   (fire),
        .count (rate_cnt)
    );

    // Detector FSM, window position and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= ARMED;
            first_seen <= 1'b0;
            win_pos    <= '0;
            spike      <= 1'b0;
            isi_valid  <= 1'b0;
            isi_data   <= '0;
            burst      <= 1'b0;
            rate_valid <= 1'b0;
            rate_count <= '0;
            overflow   <= 1'b0;
        end else begin
            spike      <= fire;
            rate_valid <= v_valid && win_last;

            if (fire) begin
                state      <= FIRED;
                first_seen <= 1'b1;
            end else if (rearm) begin
                state <= ARMED;
            end

            if (v_valid) begin
                win_pos <= win_last ? '0 : win_pos + WIN_W'(1);
            end

            if (accept) begin
                isi_valid <= 1'b0;
            end

            // A new event loads unless the pending one is still stalled, in which case it is lost.
            if (new_evt) begin
                burst <= burst_now;
                if (isi_valid && !isi_ready) begin
                    overflow <= 1'b1;
                end else begin
                    isi_valid <= 1'b1;
                    isi_data  <= isi_cnt;
                end
            end

            // Window result includes a spike on the window's last sample.
            if (v_valid && win_last) begin
                rate_count <= fire ? rate_next : rate_cnt;
            end
        end
    end

endmodule

// File: tb/tb_izh_spike_decoder.sv
// Directed bench for izh_spike_decoder: table of hysteresis/ISI vectors plus hand-written
// sequences for backpressure, mid-operation reset, ISI saturation and the rate window.
module tb_izh_spike_decoder;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       v_valid;
    logic [7:0] v_in;
    logic       isi_ready;

    logic        spike_a, isi_valid_a, burst_a, rate_valid_a, overflow_a;
    logic [15:0] isi_data_a;
    logic [9:0]  rate_count_a;

    logic        spike_b, isi_valid_b, burst_b, rate_valid_b, overflow_b;
    logic [3:0]  isi_data_b;
    logic [9:0]  rate_count_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        vv;
        logic [7:0]  vin;
        logic        e_spike;
        logic        e_valid;
        logic [15:0] e_data;
        logic        e_burst;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    izh_spike_decoder #(
        .ISI_W   (16),
        .WIN_LEN (16),
        .RATE_W  (10)
    ) dut_a (
        .clk        (clk),
        .rst_n      (rst_n),
        .v_valid    (v_valid),
        .v_in       (v_in),
        .spike      (spike_a),
        .isi_valid  (isi_valid_a),
        .isi_ready  (isi_ready),
        .isi_data   (isi_data_a),
        .burst      (burst_a),
        .rate_valid (rate_valid_a),
        .rate_count (rate_count_a),
        .overflow   (overflow_a)
    );

    izh_spike_decoder #(
        .ISI_W (4)
    ) dut_b (
        .clk        (clk),
        .rst_n      (rst_n),
        .v_valid    (v_valid),
        .v_in       (v_in),
        .spike      (spike_b),
        .isi_valid  (isi_valid_b),
        .isi_ready  (isi_ready),
        .isi_data   (isi_data_b),
        .burst      (burst_b),
        .rate_valid (rate_valid_b),
        .rate_count (rate_count_b),
        .overflow   (overflow_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic samp(input logic [7:0] v);
        v_valid = 1'b1;
        v_in    = v;
        step();
    endtask

    task automatic add(input logic vv, input logic [7:0] vin, input logic sp, input logic vl,
                       input logic [15:0] d, input logic b);
        vec_t r;
        r.vv = vv; r.vin = vin; r.e_spike = sp; r.e_valid = vl; r.e_data = d; r.e_burst = b;
        tbl.push_back(r);
    endtask

    task automatic pulse_reset();
        rst_n   = 1'b0;
        v_valid = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        // Hysteresis and ISI vectors; each row is one cycle with isi_ready held high.
        add(1, 8'h13, 0, 0,  0, 0);   // equal to threshold: no fire
        add(1, 8'h14, 1, 0,  0, 0);   // first spike: no event
        for (int i = 0; i < 4; i++) add(1, 8'h14, 0, 0, 0, 0);
        add(1, 8'h00, 0, 0,  0, 0);   // equal to rearm: stays fired
        add(1, 8'h14, 0, 0,  0, 0);
        add(1, 8'hFF, 0, 0,  0, 0);   // rearm
        add(1, 8'h14, 1, 1,  8, 0);   // second spike, ISI 8
        add(1, 8'hC0, 0, 0,  8, 0);
        add(1, 8'h20, 1, 1,  2, 1);   // ISI 2 -> burst
        add(1, 8'h00, 0, 0,  2, 1);
        add(1, 8'hFF, 0, 0,  2, 1);
        add(0, 8'h7F, 0, 0,  2, 1);   // invalid cycle ignored while armed
        for (int i = 0; i < 7; i++) add(1, 8'h00, 0, 0, 2, 1);
        add(1, 8'h20, 1, 1, 10, 0);   // ISI 10
        add(1, 8'hFF, 0, 0, 10, 0);
        add(1, 8'h00, 0, 0, 10, 0);
        add(1, 8'h14, 1, 1,  3, 1);   // ISI 3 -> burst

        // Reset held for three cycles with a high input.
        rst_n = 1'b0; v_valid = 1'b1; v_in = 8'h40; isi_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_spike", spike_a, 0);
            chk("rst_isi_valid", isi_valid_a, 0);
            chk("rst_isi_data", isi_data_a, 0);
            chk("rst_burst", burst_a, 0);
            chk("rst_rate_valid", rate_valid_a, 0);
            chk("rst_rate_count", rate_count_a, 0);
            chk("rst_overflow", overflow_a, 0);
        end
        rst_n = 1'b1; v_valid = 1'b0;
        step();
        chk("post_rst_spike", spike_a, 0);

        foreach (tbl[i]) begin
            v_valid = tbl[i].vv;
            v_in    = tbl[i].vin;
            step();
            chk($sformatf("tbl%0d_spike", i), spike_a, tbl[i].e_spike);
            chk($sformatf("tbl%0d_isi_valid", i), isi_valid_a, tbl[i].e_valid);
            chk($sformatf("tbl%0d_isi_data", i), isi_data_a, tbl[i].e_data);
            chk($sformatf("tbl%0d_burst", i), burst_a, tbl[i].e_burst);
            chk($sformatf("tbl%0d_overflow", i), overflow_a, 0);
        end

        // Backpressure: spikes at 0, 20, 30 with the consumer stalled.
        pulse_reset();
        isi_ready = 1'b0;
        samp(8'h20);
        chk("bp_first_spike", spike_a, 1);
        chk("bp_first_no_evt", isi_valid_a, 0);
        samp(8'hFF);
        repeat (18) samp(8'h00);
        samp(8'h20);
        chk("bp_evt20_valid", isi_valid_a, 1);
        chk("bp_evt20_data", isi_data_a, 20);
        chk("bp_evt20_ovf", overflow_a, 0);
        samp(8'hFF);
        repeat (8) samp(8'h00);
        chk("bp_hold_data", isi_data_a, 20);
        samp(8'h20);
        chk("bp_drop_spike", spike_a, 1);
        chk("bp_drop_data", isi_data_a, 20);
        chk("bp_drop_ovf", overflow_a, 1);
        samp(8'hFF);
        samp(8'h00);
        chk("bp_pre_accept_valid", isi_valid_a, 1);
        chk("bp_pre_accept_data", isi_data_a, 20);
        isi_ready = 1'b1;
        samp(8'h20);
        chk("bp_reload_valid", isi_valid_a, 1);
        chk("bp_reload_data", isi_data_a, 3);
        chk("bp_reload_burst", burst_a, 1);
        chk("bp_ovf_sticky", overflow_a, 1);

        // Reset while an event is pending.
        isi_ready = 1'b0;
        rst_n = 1'b0; v_valid = 1'b1; v_in = 8'h40;
        step();
        chk("mrst_isi_valid", isi_valid_a, 0);
        chk("mrst_overflow", overflow_a, 0);
        chk("mrst_burst", burst_a, 0);
        rst_n = 1'b1;
        samp(8'h40);
        chk("mrst_spike", spike_a, 1);
        chk("mrst_no_evt", isi_valid_a, 0);
        samp(8'hFF);
        samp(8'h40);
        chk("mrst_evt_valid", isi_valid_a, 1);
        chk("mrst_evt_data", isi_data_a, 2);

        // ISI gap of 40: full width reports 40, the 4-bit instance saturates at 15.
        isi_ready = 1'b1;
        samp(8'hFF);
        repeat (38) samp(8'h00);
        samp(8'h40);
        chk("sat_a_valid", isi_valid_a, 1);
        chk("sat_a_data", isi_data_a, 40);
        chk("sat_b_valid", isi_valid_b, 1);
        chk("sat_b_data", isi_data_b, 15);
        chk("sat_b_burst", burst_b, 0);

        // Rate window of 16 with a spike every 4 samples, the last one on the window end.
        pulse_reset();
        for (int p = 0; p < 48; p++) begin
            if (p % 4 == 3) samp(8'h20);
            else if (p % 4 == 0) samp(8'hFF);
            else samp(8'h00);
            chk($sformatf("rate_valid_p%0d", p), rate_valid_a, (p % 16 == 15) ? 1 : 0);
            if (p % 16 == 15) begin
                chk($sformatf("rate_count_p%0d", p), rate_count_a, 4);
                chk($sformatf("rate_spike_p%0d", p), spike_a, 1);
            end
        end
        chk("rate_b_no_window", rate_valid_b, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
